// File: rtl/seq_debug_cmd_mailbox.sv
// Sequencer core-debug command mailbox: Avalon-MM slave that captures a host command
// and its parameters, hands them to the sequencer over valid/ready, and records the result.
module seq_debug_cmd_mailbox #(
  parameter int unsigned DEBUG_BASE = 'h15018,
  parameter int unsigned NUM_PARAMS = 4,
  parameter int unsigned ADDR_WIDTH = 20
) (
  input  logic                     avl_clk,
  input  logic                     avl_reset_n,
  input  logic [ADDR_WIDTH-1:0]    avl_address,
  input  logic                     avl_write,
  input  logic [31:0]              avl_writedata,
  input  logic                     avl_read,
  output logic [31:0]              avl_readdata,
  output logic                     avl_readdatavalid,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [31:0]              cmd_word,
  output logic [32*NUM_PARAMS-1:0] cmd_params,
  input  logic                     cmd_done,
  input  logic [7:0]               cmd_result
);

  localparam int unsigned WORD_W = ADDR_WIDTH - 2;
  localparam logic [WORD_W-1:0] REQ_WORD    = WORD_W'((DEBUG_BASE + 8) >> 2);
  localparam logic [WORD_W-1:0] STATUS_WORD = WORD_W'((DEBUG_BASE + 12) >> 2);
  localparam logic [WORD_W-1:0] PARAM_WORD  = WORD_W'((DEBUG_BASE + 16) >> 2);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_BUSY    = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]            state;
  logic [7:0]            result;
  logic                  overrun;
  logic [31:0]           params [NUM_PARAMS];

  logic [WORD_W-1:0]     addr_word;
  logic                  req_hit;
  logic                  status_hit;
  logic [NUM_PARAMS-1:0] param_sel;
  logic                  param_hit;
  logic                  accept;
  logic [31:0]           status_word;
  logic [31:0]           rd_data;
  logic                  unused_addr_lsbs;

  assign addr_word        = avl_address[ADDR_WIDTH-1:2];
  assign unused_addr_lsbs = ^avl_address[1:0];
  assign req_hit          = (addr_word == REQ_WORD);
  assign status_hit       = (addr_word == STATUS_WORD);
  assign param_hit        = |param_sel;

  // New commands and parameter updates are only taken while the sequencer is not holding them.
  assign accept      = (state == ST_IDLE) || (state == ST_DONE);
  assign cmd_valid   = (state == ST_PENDING);
  assign status_word = {15'd0, overrun, result, 6'd0, state};

  always_comb begin
    param_sel = '0;
    for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
      param_sel[i] = (addr_word == PARAM_WORD + WORD_W'(i));
    end
  end

  always_comb begin
    cmd_params = '0;
    for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
      cmd_params[32*i +: 32] = params[i];
    end
  end

  always_comb begin
    rd_data = '0;
    if (req_hit) begin
      rd_data = cmd_word;
    end else if (status_hit) begin
      rd_data = status_word;
    end else begin
      for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
        if (param_sel[i]) begin
          rd_data = params[i];
        end
      end
    end
  end

  // Handshake progress first; a bus write in the same cycle only overrides state from IDLE/DONE,
  // so cmd_done plus a CMD_STATUS write in BUSY still lands in DONE.
  always_ff @(posedge avl_clk or negedge avl_reset_n) begin
    if (!avl_reset_n) begin
      state    <= ST_IDLE;
      cmd_word <= '0;
      result   <= '0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        ST_PENDING: if (cmd_ready) state <= ST_BUSY;
        ST_BUSY: begin
          if (cmd_done) begin
            result <= cmd_result;
            state  <= ST_DONE;
          end
        end
        default: ;
      endcase
      if (avl_write) begin
        if (req_hit) begin
          if (accept) begin
            cmd_word <= avl_writedata;
            result   <= '0;
            state    <= ST_PENDING;
          end else begin
            overrun <= 1'b1;
          end
        end
        if (param_hit && !accept) begin
          overrun <= 1'b1;
        end
        if (status_hit) begin
          overrun <= 1'b0;
          if (state == ST_DONE) begin
            state <= ST_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge avl_clk or negedge avl_reset_n) begin
    if (!avl_reset_n) begin
      for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
        params[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
        if (avl_write && param_sel[i] && accept) begin
          params[i] <= avl_writedata;
        end
      end
    end
  end

  always_ff @(posedge avl_clk or negedge avl_reset_n) begin
    if (!avl_reset_n) begin
      avl_readdata      <= '0;
      avl_readdatavalid <= 1'b0;
    end else begin
      avl_readdatavalid <= avl_read;
      avl_readdata      <= avl_read ? rd_data : '0;
    end
  end

endmodule

// File: doc/seq_debug_cmd_mailbox.md
# seq_debug_cmd_mailbox

Avalon-MM slave implementing the sequencer core-debug command mailbox at the debug window (base 0x15018; REQ_CMD 0x15020, CMD_STATUS 0x15024, CMD_PARAMS from 0x15028). It sits between the host/JTAG bus master and the sequencer core. It captures a host command plus its parameters, presents them to the sequencer over a valid/ready handshake, then records completion and a result code for host polling.

## Interface
- DEBUG_BASE, 'h15018, byte address of the debug window; CMD_BASE = DEBUG_BASE+8
- NUM_PARAMS, 4, number of 32-bit parameter words (1..8) starting at CMD_BASE+8
- ADDR_WIDTH, 20, avl_address width in bytes
- avl_clk  in  1  single clock; all logic is rising-edge
- avl_reset_n  in  1  asynchronous, active-low reset
- avl_address  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- avl_write  in  1  write strobe; always accepted with no waitrequest
- avl_writedata  in  32  write data
- avl_read  in  1  read strobe
- avl_readdata  out  32  read data, valid with avl_readdatavalid
- avl_readdatavalid  out  1  one-cycle pulse, exactly 1 cycle after avl_read
- cmd_valid  out  1  command presented to the sequencer
- cmd_ready  in  1  sequencer accepts the command
- cmd_word  out  32  latched REQ_CMD value
- cmd_params  out  32*NUM_PARAMS  parameter words; word i at bits [32i+31:32i]
- cmd_done  in  1  sequencer completion pulse
- cmd_result  in  8  result code, sampled with cmd_done

## Operation
- Register map (offsets from CMD_BASE): 0x0 REQ_CMD (R/W), 0x4 CMD_STATUS (R, write = clear), 0x8+4i PARAM[i] (R/W). All other addresses read 0, and writes to them are dropped.
- CMD_STATUS layout: [1:0] state (0 IDLE, 1 PENDING, 2 BUSY, 3 DONE); [15:8] result; [16] overrun (sticky); other bits 0.
- FSM:
  - IDLE or DONE, REQ_CMD write: latch data into cmd_word, clear result, go to PENDING.
  - PENDING: cmd_valid=1. On cmd_valid&cmd_ready, go to BUSY.
  - BUSY, cmd_done: latch cmd_result, go to DONE.
  - DONE, CMD_STATUS write: go to IDLE. Clears overrun; result is kept.
  - IDLE, CMD_STATUS write: clears overrun only.
- REQ_CMD or PARAM write while PENDING or BUSY: write ignored, overrun set, state unchanged.
- PARAM writes in IDLE or DONE update the parameter word immediately.
- cmd_word and cmd_params stay stable from PENDING entry until the FSM returns to IDLE or DONE.
- cmd_done outside BUSY is ignored.
- CMD_STATUS write in PENDING or BUSY: clears overrun only; state unchanged.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream) clears everything: state IDLE, cmd_valid 0, cmd_word 0, all params 0, result 0, overrun 0, avl_readdata 0, avl_readdatavalid 0.
- Reset mid-command drops the command silently; the sequencer must tolerate cmd_valid falling.
- Writes take effect on the clock edge that samples avl_write. A REQ_CMD write at edge N gives cmd_valid=1 after edge N.
- Handshake:
  - Transfer occurs on an edge with cmd_valid&cmd_ready. cmd_valid falls on that same edge.
  - cmd_ready may be held high; minimum PENDING dwell is 1 cycle.
- cmd_done may arrive in the cycle immediately after the transfer edge.
- Read latency is 1 cycle. Readdata reflects register state before any same-edge write.
- Simultaneous events in one cycle:
  - cmd_done and CMD_STATUS write in BUSY: DONE taken; overrun cleared.
  - REQ_CMD write and CMD_STATUS write cannot coincide (single port).
  - avl_read and avl_write both high: both performed; read returns pre-write value.

## Test plan
- Reset: assert avl_reset_n=0 mid-PENDING -> cmd_valid=0 within the same cycle (async); status reads 0x00000000 after release.
- Basic command:
  - Stimulus: write PARAM0=0xDEADBEEF, PARAM1=0x12; REQ_CMD=0x00000005; cmd_ready=1 two cycles later; cmd_done with result 0x3C after four more cycles.
  - Response: status reads 1, then 2, then 0x00003C03. cmd_params[63:0] = 0x00000012_DEADBEEF throughout.
- Overrun:
  - Stimulus: in BUSY, write REQ_CMD=0x9 and PARAM0=0x1.
  - Response: cmd_word stays 0x5; PARAM0 unchanged; status bit16=1. A CMD_STATUS write clears bit16 and leaves state BUSY.
- Back-to-back:
  - Stimulus: in DONE, write REQ_CMD=0x7 directly.
  - Response: state PENDING; result field reads 0.
- Simultaneous: cmd_done (result 0x01) and CMD_STATUS write on the same edge in BUSY -> status 0x00000103.
- Address decode: read 0x15018 and 0x15028+4*NUM_PARAMS -> 0 with readdatavalid 1 cycle later. Writes there change no state.
